// File: rtl/psum_accumulator_if.sv
// -----------------------------------------------------------------------------
// psum_accumulator_if
// Bundles the issue-side credit handshake, the MAC partial-sum input, the
// result valid/ready stream and the sticky group error of psum_accumulator.
//
// Parameters (must match the psum_accumulator instance they connect to):
//   bw_psum  signed psum width from the MAC
//   bw_acc   signed accumulator / result width
//   len_w    acc_len width
//
// Signals:
//   issue        producer -> acc  a/b presented to the MAC this cycle
//   issue_last   producer -> acc  this issue closes the current group
//   issue_ready  acc -> producer  upstream may issue
//   acc_len      producer -> acc  group length minus 1 (sampled on first psum)
//   psum_in      MAC -> acc       MAC output, aligned with the delayed valid
//   res_valid    acc -> consumer  result FIFO non-empty
//   res_ready    consumer -> acc  consumer accepts res_data
//   res_data     acc -> consumer  head-of-FIFO result
//   grp_err      acc -> consumer  sticky issue_last / acc_len disagreement
//
// Modports: master = producer/consumer side, slave = psum_accumulator.
// -----------------------------------------------------------------------------
interface psum_accumulator_if #(
  parameter int unsigned bw_psum = 20,
  parameter int unsigned bw_acc  = 24,
  parameter int unsigned len_w   = 4
);
  logic                      issue;
  logic                      issue_last;
  logic                      issue_ready;
  logic [len_w-1:0]          acc_len;
  logic signed [bw_psum-1:0] psum_in;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [bw_acc-1:0]  res_data;
  logic                      grp_err;

  modport master (
    output issue, issue_last, acc_len, psum_in, res_ready,
    input  issue_ready, res_valid, res_data, grp_err
  );

  modport slave (
    input  issue, issue_last, acc_len, psum_in, res_ready,
    output issue_ready, res_valid, res_data, grp_err
  );
endinterface

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Sits downstream of the 8-input MAC. A delay line carries {issue, issue_last}
// alongside the MAC pipeline so the delayed valid lines up with psum_in.
// acc_len+1 consecutive partial sums are accumulated (saturating, signed) into
// one result which is pushed into a small output FIFO drained by a valid/ready
// handshake. Upstream is throttled by credits: issue_ready only when the FIFO
// has more free slots than group-closing issues still inside the MAC, so a
// psum already in flight is never dropped.
//
// Parameters:
//   bw_psum  signed psum width from MAC
//   bw_acc   signed accumulator / result width
//   mac_lat  MAC latency in cycles (>= 1)
//   depth    output FIFO entries (power of 2, >= 2)
//   len_w    acc_len width; group length = acc_len + 1
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      psum_accumulator_if.slave (issue/credit, psum, result, grp_err)
//
// Build option:
//   RELU_EN  when defined, each pushed result is max(0, saturated sum);
//            otherwise the signed saturated sum is pushed unchanged.
// -----------------------------------------------------------------------------
module psum_accumulator #(
  parameter int unsigned bw_psum = 20,
  parameter int unsigned bw_acc  = 24,
  parameter int unsigned mac_lat = 3,
  parameter int unsigned depth   = 4,
  parameter int unsigned len_w   = 4
) (
  input logic               clk,
  input logic               reset_n,
  psum_accumulator_if.slave bus
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth + 1);
  localparam int unsigned IW = $clog2(mac_lat + 1);
  localparam int unsigned KW = ((CW > IW) ? CW : IW) + 1;

  localparam logic signed [bw_acc-1:0] ACC_MAX = {1'b0, {(bw_acc-1){1'b1}}};
  localparam logic signed [bw_acc-1:0] ACC_MIN = {1'b1, {(bw_acc-1){1'b0}}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Valid / last delay line matching the MAC latency
  // ---------------------------------------------------------------------------
  logic [mac_lat-1:0] vld_sr_q, vld_sr_d;
  logic [mac_lat-1:0] last_sr_q, last_sr_d;
  logic               mac_vld;
  logic               mac_last;
  logic [IW-1:0]      inflight_last;

  always_comb begin
    vld_sr_d     = vld_sr_q;
    last_sr_d    = last_sr_q;
    vld_sr_d[0]  = bus.issue;
    last_sr_d[0] = bus.issue & bus.issue_last;
    for (int unsigned i = 1; i < mac_lat; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
    end
  end

  assign mac_vld  = vld_sr_q[mac_lat-1];
  assign mac_last = last_sr_q[mac_lat-1];

  // Every group-closing issue still in the MAC will need a FIFO slot.
  always_comb begin
    inflight_last = '0;
    for (int unsigned i = 0; i < mac_lat; i++) begin
      inflight_last = inflight_last + IW'(last_sr_q[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating accumulate
  // ---------------------------------------------------------------------------
  logic signed [bw_acc-1:0] acc_q, acc_d;
  logic signed [bw_acc-1:0] psum_ext;
  logic signed [bw_acc:0]   sum_wide;
  logic signed [bw_acc-1:0] acc_sat;
  logic signed [bw_acc-1:0] push_data;

  assign psum_ext = bw_acc'(bus.psum_in);
  assign sum_wide = (bw_acc+1)'(acc_q) + (bw_acc+1)'(psum_ext);

  // One guard bit: top two bits differing means the sum left the bw_acc range.
  always_comb begin
    if (sum_wide[bw_acc] != sum_wide[bw_acc-1]) begin
      acc_sat = sum_wide[bw_acc] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = sum_wide[bw_acc-1:0];
    end
  end

`ifdef RELU_EN
  assign push_data = acc_sat[bw_acc-1] ? '0 : acc_sat;
`else
  assign push_data = acc_sat;
`endif

  // ---------------------------------------------------------------------------
  // Group FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [len_w-1:0] cnt_q, cnt_d;
  logic [len_w-1:0] len_q, len_d;
  logic [len_w-1:0] cur_len;
  logic             group_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // In IDLE acc_q and cnt_q are zero, so the same sum/compare paths serve the
  // first psum of a group; only the length source differs (live acc_len).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    cur_len    = (state_q == S_IDLE) ? bus.acc_len : len_q;
    group_done = mac_vld & (cnt_q == cur_len);

    unique case (state_q)
      S_IDLE: begin
        if (mac_vld) begin
          if (group_done) begin
            acc_d = '0;
            cnt_d = '0;
          end else begin
            state_d = S_ACCUM;
            acc_d   = acc_sat;
            cnt_d   = len_w'(1);
            len_d   = bus.acc_len;
          end
        end
      end
      S_ACCUM: begin
        if (mac_vld) begin
          if (group_done) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_sat;
            cnt_d = cnt_q + len_w'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky group-boundary mismatch (counter still decides boundaries)
  // ---------------------------------------------------------------------------
  logic grp_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grp_err_q <= 1'b0;
    end else if (mac_vld && (mac_last != group_done)) begin
      grp_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------------
  logic signed [bw_acc-1:0] mem [depth];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            rd_next;
  logic [CW-1:0]            fifo_cnt_q, fifo_cnt_d;
  logic signed [bw_acc-1:0] head_q, head_d;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop;
  logic                     do_push;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CW'(depth));
  assign pop        = !fifo_empty && bus.res_ready;
  assign do_push    = group_done && (!fifo_full || pop);
  assign rd_next    = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    head_d     = head_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_next;

    unique case ({do_push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // The head register takes the incoming word when it becomes the oldest
    // entry, otherwise the next stored word after a pop.
    if (do_push && (fifo_empty || (fifo_cnt_q == CW'(1) && pop))) begin
      head_d = push_data;
    end else if (pop && (fifo_cnt_q > CW'(1))) begin
      head_d = mem[rd_next];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [KW-1:0] free_slots;

  assign free_slots      = KW'(depth) - KW'(fifo_cnt_q);
  assign bus.issue_ready = (free_slots > KW'(inflight_last));
  assign bus.res_valid   = !fifo_empty;
  assign bus.res_data    = head_q;
  assign bus.grp_err     = grp_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  localparam int unsigned BW_PSUM = 20;
  localparam int unsigned BW_ACC  = 24;
  localparam int unsigned MAC_LAT = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LEN_W   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  psum_accumulator_if #(.bw_psum(BW_PSUM), .bw_acc(BW_ACC), .len_w(LEN_W)) bus ();

  psum_accumulator #(
    .bw_psum(BW_PSUM),
    .bw_acc (BW_ACC),
    .mac_lat(MAC_LAT),
    .depth  (DEPTH),
    .len_w  (LEN_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // MAC stand-in: operand value and its group length travel MAC_LAT cycles.
  logic signed [BW_PSUM-1:0] mac_a = '0;
  logic [LEN_W-1:0]          len_a = '0;
  logic signed [BW_PSUM-1:0] psum_pipe [MAC_LAT];
  logic [LEN_W-1:0]          len_pipe  [MAC_LAT];

  initial begin
    for (int i = 0; i < int'(MAC_LAT); i++) begin
      psum_pipe[i] = '0;
      len_pipe[i]  = '0;
    end
  end

  always @(posedge clk) begin
    psum_pipe[0] <= mac_a;
    len_pipe[0]  <= len_a;
    for (int i = 1; i < int'(MAC_LAT); i++) begin
      psum_pipe[i] <= psum_pipe[i-1];
      len_pipe[i]  <= len_pipe[i-1];
    end
  end

  assign bus.psum_in = psum_pipe[MAC_LAT-1];
  assign bus.acc_len = len_pipe[MAC_LAT-1];

  // Scoreboard and reference model
  int checks = 0;
  int errors = 0;
  logic signed [BW_ACC-1:0] exp_q[$];
  int    m_cnt;
  int    m_len;
  longint m_sum;
  bit    m_err;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (BW_ACC-1)) - 1;
    lo = -(longint'(1) <<< (BW_ACC-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_len = 0;
    m_sum = 0;
    m_err = 1'b0;
  endtask

  // Groups are counted in issues; each step of the running sum is clamped.
  task automatic model_issue(input int v, input bit last, input int len);
    longint r;
    bit     done;
    if (m_cnt == 0) m_len = len;
    m_sum = sat(m_sum + longint'(v));
    m_cnt++;
    done = (m_cnt == m_len + 1);
    if (last != done) m_err = 1'b1;
    if (done) begin
      r = m_sum;
`ifdef RELU_EN
      if (r < 0) r = 0;
`endif
      exp_q.push_back(BW_ACC'(r));
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic issue_psum(input int v, input bit last, input int len);
    int guard = 0;
    while (!bus.issue_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.issue_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready_timeout: got 0, expected 1 within 1000 cycles");
      return;
    end
    bus.issue      = 1'b1;
    bus.issue_last = last;
    mac_a          = BW_PSUM'(v);
    len_a          = LEN_W'(len);
    model_issue(v, last, len);
    @(negedge clk);
    bus.issue      = 1'b0;
    bus.issue_last = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rand_ready    = 1'b0;
    bus.res_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    check("drain_empty_res_valid", longint'(bus.res_valid), 0);
  endtask

  // Monitor: a transfer seen here is popped by the DUT on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (reset_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_data %0d, expected no result", bus.res_data);
      end else begin
        check("res_data", longint'(bus.res_data), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len;
    int v;
    bus.issue      = 1'b0;
    bus.issue_last = 1'b0;
    bus.res_ready  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_issue_ready", longint'(bus.issue_ready), 1);
    check("rst_res_valid",   longint'(bus.res_valid), 0);
    check("rst_res_data",    longint'(bus.res_data), 0);
    check("rst_grp_err",     longint'(bus.grp_err), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic group of four and its latency
    bus.res_ready = 1'b1;
    issue_psum(10, 0, 3);
    issue_psum(-3, 0, 3);
    issue_psum(7, 0, 3);
    issue_psum(100, 1, 3);
    repeat (2) @(negedge clk);
    check("t1_valid_before_latency", longint'(bus.res_valid), 0);
    @(negedge clk);
    check("t1_valid_at_latency", longint'(bus.res_valid), 1);
    check("t1_res_data", longint'(bus.res_data), 114);
    check("t1_grp_err", longint'(bus.grp_err), longint'(m_err));
    drain();

    // Credits with the consumer stalled
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_psum(100 * (i + 1), 1, 0);
    check("t2_credit_stall", longint'(bus.issue_ready), 0);
    repeat (6) @(negedge clk);
    check("t2_full_stall", longint'(bus.issue_ready), 0);
    check("t2_full_valid", longint'(bus.res_valid), 1);
    check("t2_full_head",  longint'(bus.res_data), 100);
    bus.res_ready = 1'b1;
    issue_psum(500, 1, 0);
    issue_psum(600, 1, 0);
    drain();

    // Extreme psums over the longest group
    for (int i = 0; i < 16; i++) issue_psum(524287, i == 15, 15);
    for (int i = 0; i < 16; i++) issue_psum(-524288, i == 15, 15);
    drain();

    // Push and pop in the same cycle while full (closing issue without last)
    bus.res_ready = 1'b0;
    issue_psum(11, 1, 0);
    issue_psum(22, 1, 0);
    issue_psum(33, 1, 0);
    repeat (5) @(negedge clk);
    issue_psum(44, 0, 0);
    issue_psum(55, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("t4_full_no_credit", longint'(bus.issue_ready), 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("t4_still_full", longint'(bus.issue_ready), 0);
    check("t4_valid", longint'(bus.res_valid), 1);
    check("t4_grp_err", longint'(bus.grp_err), longint'(m_err));
    drain();

    // Asynchronous reset in the middle of a group
    bus.res_ready = 1'b0;
    issue_psum(77, 1, 0);
    repeat (5) @(negedge clk);
    check("t5_pre_valid", longint'(bus.res_valid), 1);
    issue_psum(1000, 0, 3);
    issue_psum(2000, 0, 3);
    repeat (3) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check("t5_rst_issue_ready", longint'(bus.issue_ready), 1);
    check("t5_rst_res_valid",   longint'(bus.res_valid), 0);
    check("t5_rst_res_data",    longint'(bus.res_data), 0);
    check("t5_rst_grp_err",     longint'(bus.grp_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b1;
    issue_psum(5, 0, 1);
    issue_psum(6, 1, 1);
    drain();
    check("t5_grp_err_clean", longint'(bus.grp_err), longint'(m_err));

    // issue_last out of step with acc_len; negative group
    issue_psum(-20, 0, 1);
    issue_psum(-30, 0, 1);
    issue_psum(-40, 1, 1);
    issue_psum(-1, 0, 1);
    drain();
    check("t6_grp_err_set", longint'(bus.grp_err), longint'(m_err));

    // Randomized groups with a random consumer
    rand_ready = 1'b1;
    for (int g = 0; g < 150; g++) begin
      len = int'($urandom_range(0, 15));
      for (int k = 0; k <= len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          v = int'($urandom_range(0, (1 << BW_PSUM) - 1)) - (1 << (BW_PSUM - 1));
        end else begin
          v = int'($urandom_range(0, 2000)) - 1000;
        end
        issue_psum(v, k == len, len);
        if ($urandom_range(0, 7) == 0) @(negedge clk);
      end
    end
    drain();
    check("rand_grp_err_sticky", longint'(bus.grp_err), longint'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
